// File: rtl/ctrl_wave_panel_multi_if.sv
// ctrl_wave_panel_multi_if
// Bundles the board keys, channel select and lock inputs with the per-channel
// gain/phase outputs, field/step status, display value and change pulse.
//   master : panel driver side (drives keys, channel select, lock)
//   slave  : the panel controller (drives settings and display outputs)
// Parameters must match those of the controller instance.
interface ctrl_wave_panel_multi_if #(
  parameter int NUM_CH     = 2,
  parameter int SIZE_GAIN  = 4,
  parameter int SIZE_PHASE = 10,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [3:0]                   i_btn;
  logic [CH_W-1:0]              i_ch_sel;
  logic                         i_lock;
  logic [NUM_CH*SIZE_GAIN-1:0]  o_gain;
  logic [NUM_CH*SIZE_PHASE-1:0] o_phase_step;
  logic                         o_field;
  logic [1:0]                   o_step_idx;
  logic [SIZE_PHASE:0]          o_disp_value;
  logic                         o_evt;

  modport master (
    output i_btn, i_ch_sel, i_lock,
    input  o_gain, o_phase_step, o_field, o_step_idx, o_disp_value, o_evt
  );

  modport slave (
    input  i_btn, i_ch_sel, i_lock,
    output o_gain, o_phase_step, o_field, o_step_idx, o_disp_value, o_evt
  );
endinterface

// File: rtl/ctrl_wave_panel_multi.sv
// ctrl_wave_panel_multi
// Front-panel controller for the waveform generator: NUM_CH channels, each
// with a signed gain and an unsigned NCO phase step, edited from four
// active-low board keys with auto-repeat on the inc/dec keys.
// Ports:
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   bus (slave)    : i_btn[0] step cycle, [1] field toggle, [2] inc, [3] dec;
//                    i_ch_sel, i_lock; o_gain / o_phase_step (channel 0 in
//                    LSBs), o_field, o_step_idx, o_disp_value, o_evt
// Build option: define PANEL_WRAP_EN to wrap values at the range limits
// instead of saturating (o_evt then pulses on every applied adjust).
//
// Repeat FSM states:
//   state  | meaning
//   R_IDLE | no adjust key held alone; waits for an inc or dec press
//   R_WAIT | key held, counting HOLD_CYC before auto-repeat starts
//   R_REP  | auto-repeating, one adjust every REPEAT_CYC cycles
module ctrl_wave_panel_multi #(
  parameter int NUM_CH     = 2,
  parameter int SIZE_GAIN  = 4,
  parameter int SIZE_PHASE = 10,
  parameter int GAIN_MAX   = 7,
  parameter int GAIN_MIN   = -8,
  parameter int HOLD_CYC   = 25000000,
  parameter int REPEAT_CYC = 5000000
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  ctrl_wave_panel_multi_if.slave bus
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int GW      = SIZE_GAIN + 5;
  localparam int PW      = SIZE_PHASE + 6;

  localparam logic signed [GW-1:0] G_HI  = GW'(GAIN_MAX);
  localparam logic signed [GW-1:0] G_LO  = GW'(GAIN_MIN);
  localparam logic signed [GW-1:0] G_ONE = GW'(1);
  localparam logic signed [PW-1:0] P_HI  = PW'((2 ** SIZE_PHASE) - 1);
  localparam logic signed [PW-1:0] P_LO  = PW'(1);
  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TC    = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CH_W:0]    NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_REP} rep_state_t;

  // key synchronisers; reset to "released"
  logic [3:0] sync1, sync2, sync3;
  logic [3:0] press, held;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      sync3 <= 4'hF;
    end else begin
      sync1 <= bus.i_btn;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign press = sync3 & ~sync2;
  assign held  = ~sync2;

  // repeat FSM
  rep_state_t       state_r, state_nx;
  logic [CNT_W-1:0] cnt_r;
  logic             dir_up_r;
  logic             both_held, start, stop;
  logic             adj_evt, adj_up, cnt_clr, cnt_run, dir_load;

  assign both_held = held[2] & held[3];
  // simultaneous inc/dec presses land in both_held and are dropped
  assign start     = ~both_held & (press[2] ^ press[3]);
  assign stop      = both_held | ~(dir_up_r ? held[2] : held[3]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= R_IDLE;
    else          state_r <= state_nx;
  end

  always_comb begin
    state_nx = state_r;
    case (state_r)
      R_IDLE:  if (start) state_nx = R_WAIT;
      R_WAIT: begin
        if (stop)                  state_nx = R_IDLE;
        else if (cnt_r == HOLD_TC) state_nx = R_REP;
      end
      R_REP:   if (stop) state_nx = R_IDLE;
      default: state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    adj_evt  = 1'b0;
    adj_up   = dir_up_r;
    cnt_clr  = 1'b0;
    cnt_run  = 1'b0;
    dir_load = 1'b0;
    case (state_r)
      R_IDLE: begin
        if (start) begin
          adj_evt  = 1'b1;
          adj_up   = press[2];
          cnt_clr  = 1'b1;
          dir_load = 1'b1;
        end
      end
      R_WAIT: begin
        if (!stop) begin
          if (cnt_r == HOLD_TC) begin
            adj_evt = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_run = 1'b1;
          end
        end
      end
      R_REP: begin
        if (!stop) begin
          if (cnt_r == REP_TC) begin
            adj_evt = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_run = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r    <= '0;
      dir_up_r <= 1'b0;
    end else begin
      if (cnt_clr)      cnt_r <= '0;
      else if (cnt_run) cnt_r <= cnt_r + CNT_W'(1);
      if (dir_load)     dir_up_r <= press[2];
    end
  end

  // settings
  logic signed [SIZE_GAIN-1:0] gain_r  [NUM_CH];
  logic [SIZE_PHASE-1:0]       phase_r [NUM_CH];
  logic                        field_r;
  logic [1:0]                  step_idx_r;
  logic [SIZE_PHASE:0]         disp_r;
  logic                        evt_r;

  logic                        ch_ok;
  logic [CH_W-1:0]             ch_idx;
  logic signed [SIZE_GAIN-1:0] gain_cur, gain_new;
  logic [SIZE_PHASE-1:0]       phase_cur, phase_new;
  logic [4:0]                  step_val;
  logic signed [GW-1:0]        g_cur, g_step, g_sum, g_res;
  logic signed [PW-1:0]        p_cur, p_step, p_sum, p_res;
  logic                        adj_ok, gain_we, phase_we, step_we, field_we;
  logic                        gain_chg, phase_chg, evt_nx;

  assign ch_ok     = {1'b0, bus.i_ch_sel} < NUM_CH_L;
  assign ch_idx    = ch_ok ? bus.i_ch_sel : '0;
  assign gain_cur  = gain_r[ch_idx];
  assign phase_cur = phase_r[ch_idx];

  always_comb begin
    case (step_idx_r)
      2'd1:    step_val = 5'd4;
      2'd2:    step_val = 5'd16;
      default: step_val = 5'd1;
    endcase
  end

  always_comb begin
    g_cur  = GW'(gain_cur);
    g_step = $signed(GW'(step_val));
    g_sum  = adj_up ? (g_cur + g_step) : (g_cur - g_step);
`ifdef PANEL_WRAP_EN
    if (g_sum > G_HI)      g_res = g_sum - G_HI + G_LO - G_ONE;
    else if (g_sum < G_LO) g_res = g_sum - G_LO + G_HI + G_ONE;
    else                   g_res = g_sum;
`else
    if (g_sum > G_HI)      g_res = G_HI;
    else if (g_sum < G_LO) g_res = G_LO;
    else                   g_res = g_sum;
`endif
    gain_new = g_res[SIZE_GAIN-1:0];
  end

  // phase lives in [1, 2^SIZE_PHASE-1]; zero is never stored
  always_comb begin
    p_cur  = $signed(PW'(phase_cur));
    p_step = $signed(PW'(step_val));
    p_sum  = adj_up ? (p_cur + p_step) : (p_cur - p_step);
`ifdef PANEL_WRAP_EN
    if (p_sum > P_HI)      p_res = p_sum - P_HI;
    else if (p_sum < P_LO) p_res = p_sum + P_HI;
    else                   p_res = p_sum;
`else
    if (p_sum > P_HI)      p_res = P_HI;
    else if (p_sum < P_LO) p_res = P_LO;
    else                   p_res = p_sum;
`endif
    phase_new = p_res[SIZE_PHASE-1:0];
  end

  assign adj_ok    = adj_evt & ~bus.i_lock & ch_ok;
  assign gain_we   = adj_ok & ~field_r;
  assign phase_we  = adj_ok & field_r;
  assign step_we   = press[0] & ~bus.i_lock;
  assign field_we  = press[1] & ~bus.i_lock;
  assign gain_chg  = gain_new != gain_cur;
  assign phase_chg = phase_new != phase_cur;

`ifdef PANEL_WRAP_EN
  assign evt_nx = adj_ok | step_we | field_we;
`else
  assign evt_nx = (gain_we & gain_chg) | (phase_we & phase_chg) | step_we | field_we;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        gain_r[c]  <= SIZE_GAIN'(1);
        phase_r[c] <= SIZE_PHASE'(1);
      end
      field_r    <= 1'b0;
      step_idx_r <= 2'd0;
      disp_r     <= (SIZE_PHASE + 1)'(1);
      evt_r      <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (gain_we && ch_idx == CH_W'(c))  gain_r[c]  <= gain_new;
        if (phase_we && ch_idx == CH_W'(c)) phase_r[c] <= phase_new;
      end
      if (field_we) field_r <= ~field_r;
      if (step_we)  step_idx_r <= (step_idx_r == 2'd2) ? 2'd0 : step_idx_r + 2'd1;
      // display follows stored settings one cycle later; holds on bad channel
      if (ch_ok) disp_r <= field_r ? (SIZE_PHASE + 1)'(phase_cur)
                                   : (SIZE_PHASE + 1)'(gain_cur);
      evt_r <= evt_nx;
    end
  end

  logic [NUM_CH*SIZE_GAIN-1:0]  gain_pk;
  logic [NUM_CH*SIZE_PHASE-1:0] phase_pk;

  always_comb begin
    gain_pk  = '0;
    phase_pk = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      gain_pk[c*SIZE_GAIN +: SIZE_GAIN]    = gain_r[c];
      phase_pk[c*SIZE_PHASE +: SIZE_PHASE] = phase_r[c];
    end
  end

  assign bus.o_gain       = gain_pk;
  assign bus.o_phase_step = phase_pk;
  assign bus.o_field      = field_r;
  assign bus.o_step_idx   = step_idx_r;
  assign bus.o_disp_value = disp_r;
  assign bus.o_evt        = evt_r;
endmodule

// File: tb/tb_ctrl_wave_panel_multi.sv
// Directed bench for ctrl_wave_panel_multi: 3 channels, HOLD_CYC = 4,
// REPEAT_CYC = 2. Expected values are hand-computed for both the saturating
// and the PANEL_WRAP_EN build.
module tb_ctrl_wave_panel_multi;
`ifdef PANEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   evt_cnt;

  always #5 clk = ~clk;

  ctrl_wave_panel_multi_if #(.NUM_CH(3), .SIZE_GAIN(4), .SIZE_PHASE(10)) bus ();

  ctrl_wave_panel_multi #(
    .NUM_CH(3), .SIZE_GAIN(4), .SIZE_PHASE(10), .GAIN_MAX(7), .GAIN_MIN(-8),
    .HOLD_CYC(4), .REPEAT_CYC(2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // press key k for two cycles, release for five, counting o_evt pulses
  task automatic pulse_key(input int k);
    bus.i_btn[k] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.o_evt) evt_cnt++;
    end
    bus.i_btn[k] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_evt) evt_cnt++;
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (bus.o_gain !== 12'h111) begin errors++; $display("FAIL reset_gain got %h exp %h", bus.o_gain, 12'h111); end
    checks++; if (bus.o_phase_step !== 30'h00100401) begin errors++; $display("FAIL reset_phase got %h exp %h", bus.o_phase_step, 30'h00100401); end
    checks++; if (bus.o_field !== 1'b0) begin errors++; $display("FAIL reset_field got %b exp 0", bus.o_field); end
    checks++; if (bus.o_step_idx !== 2'd0) begin errors++; $display("FAIL reset_step got %0d exp 0", bus.o_step_idx); end
    checks++; if (bus.o_disp_value !== 11'd1) begin errors++; $display("FAIL reset_disp got %h exp 001", bus.o_disp_value); end
    checks++; if (bus.o_evt !== 1'b0) begin errors++; $display("FAIL reset_evt got %b exp 0", bus.o_evt); end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_gain_inc();
    bus.i_ch_sel = 2'd0;
    evt_cnt = 0;
    repeat (3) pulse_key(2);
    checks++; if (evt_cnt !== 3) begin errors++; $display("FAIL gain_inc_evts got %0d exp 3", evt_cnt); end
    checks++; if (bus.o_gain !== 12'h114) begin errors++; $display("FAIL gain_inc_gain got %h exp %h", bus.o_gain, 12'h114); end
    checks++; if (bus.o_disp_value !== 11'd4) begin errors++; $display("FAIL gain_inc_disp got %h exp 004", bus.o_disp_value); end
  endtask

  task automatic test_phase_field();
    logic [29:0] exp_ph;
    pulse_key(1);
    pulse_key(0);
    pulse_key(0);
    checks++; if (bus.o_field !== 1'b1) begin errors++; $display("FAIL phase_field got %b exp 1", bus.o_field); end
    checks++; if (bus.o_step_idx !== 2'd2) begin errors++; $display("FAIL phase_step got %0d exp 2", bus.o_step_idx); end
    bus.i_ch_sel = 2'd1;
    tick(2);
    checks++; if (bus.o_disp_value !== 11'd1) begin errors++; $display("FAIL phase_disp_ch1 got %h exp 001", bus.o_disp_value); end
    evt_cnt = 0;
    pulse_key(3);
    checks++; if (evt_cnt !== (WRAP ? 1 : 0)) begin errors++; $display("FAIL phase_dec_evts got %0d exp %0d", evt_cnt, WRAP ? 1 : 0); end
    evt_cnt = 0;
    pulse_key(2);
    pulse_key(2);
    exp_ph = WRAP ? 30'h00104401 : 30'h00108401;
    checks++; if (evt_cnt !== 2) begin errors++; $display("FAIL phase_inc_evts got %0d exp 2", evt_cnt); end
    checks++; if (bus.o_phase_step !== exp_ph) begin errors++; $display("FAIL phase_inc_val got %h exp %h", bus.o_phase_step, exp_ph); end
    checks++; if (bus.o_disp_value !== (WRAP ? 11'd17 : 11'd33)) begin errors++; $display("FAIL phase_inc_disp got %h exp %h", bus.o_disp_value, WRAP ? 11'd17 : 11'd33); end
  endtask

  task automatic test_hold_repeat();
    logic [19:0] mask;
    logic [19:0] exp_mask;
    pulse_key(1);
    pulse_key(0);
    bus.i_ch_sel = 2'd0;
    tick(2);
    mask = '0;
    bus.i_btn[2] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.o_evt) mask[j] = 1'b1;
      if (j == 11) bus.i_btn[2] = 1'b1;
    end
    exp_mask = WRAP ? 20'h01544 : 20'h00144;
    checks++; if (mask !== exp_mask) begin errors++; $display("FAIL hold_evt_pattern got %h exp %h", mask, exp_mask); end
    checks++; if (bus.o_gain !== (WRAP ? 12'h119 : 12'h117)) begin errors++; $display("FAIL hold_gain got %h exp %h", bus.o_gain, WRAP ? 12'h119 : 12'h117); end
  endtask

  task automatic test_both_keys();
    logic [11:0] g0;
    g0 = WRAP ? 12'h119 : 12'h117;
    bus.i_ch_sel = 2'd1;
    evt_cnt = 0;
    bus.i_btn[2] = 1'b0;
    bus.i_btn[3] = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.o_evt) evt_cnt++; end
    bus.i_btn[3] = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.o_evt) evt_cnt++; end
    checks++; if (evt_cnt !== 0) begin errors++; $display("FAIL both_evts got %0d exp 0", evt_cnt); end
    checks++; if (bus.o_gain !== g0) begin errors++; $display("FAIL both_gain got %h exp %h", bus.o_gain, g0); end
    bus.i_btn[2] = 1'b1;
    tick(4);
    evt_cnt = 0;
    pulse_key(2);
    checks++; if (evt_cnt !== 1) begin errors++; $display("FAIL both_after_evts got %0d exp 1", evt_cnt); end
    checks++; if (bus.o_gain !== (WRAP ? 12'h129 : 12'h127)) begin errors++; $display("FAIL both_after_gain got %h exp %h", bus.o_gain, WRAP ? 12'h129 : 12'h127); end
  endtask

  task automatic test_lock();
    bus.i_lock = 1'b1;
    evt_cnt = 0;
    repeat (5) pulse_key(2);
    pulse_key(1);
    checks++; if (evt_cnt !== 0) begin errors++; $display("FAIL lock_evts got %0d exp 0", evt_cnt); end
    checks++; if (bus.o_gain !== (WRAP ? 12'h129 : 12'h127)) begin errors++; $display("FAIL lock_gain got %h exp %h", bus.o_gain, WRAP ? 12'h129 : 12'h127); end
    checks++; if (bus.o_field !== 1'b0) begin errors++; $display("FAIL lock_field got %b exp 0", bus.o_field); end
    bus.i_lock = 1'b0;
  endtask

  task automatic test_out_of_range();
    bus.i_ch_sel = 2'd1;
    tick(2);
    checks++; if (bus.o_disp_value !== 11'd2) begin errors++; $display("FAIL oor_disp_ch1 got %h exp 002", bus.o_disp_value); end
    bus.i_ch_sel = 2'd3;
    evt_cnt = 0;
    pulse_key(2);
    checks++; if (evt_cnt !== 0) begin errors++; $display("FAIL oor_evts got %0d exp 0", evt_cnt); end
    checks++; if (bus.o_gain !== (WRAP ? 12'h129 : 12'h127)) begin errors++; $display("FAIL oor_gain got %h exp %h", bus.o_gain, WRAP ? 12'h129 : 12'h127); end
    pulse_key(0);
    checks++; if (bus.o_step_idx !== 2'd1) begin errors++; $display("FAIL oor_step got %0d exp 1", bus.o_step_idx); end
    checks++; if (bus.o_disp_value !== 11'd2) begin errors++; $display("FAIL oor_disp_hold got %h exp 002", bus.o_disp_value); end
    bus.i_ch_sel = 2'd0;
    tick(2);
    checks++; if (bus.o_disp_value !== (WRAP ? 11'h7F9 : 11'd7)) begin errors++; $display("FAIL oor_disp_ch0 got %h exp %h", bus.o_disp_value, WRAP ? 11'h7F9 : 11'd7); end
  endtask

  task automatic test_gain_floor();
    bus.i_ch_sel = 2'd2;
    evt_cnt = 0;
    repeat (3) pulse_key(3);
    checks++; if (evt_cnt !== 3) begin errors++; $display("FAIL floor_evts got %0d exp 3", evt_cnt); end
    checks++; if (bus.o_gain !== (WRAP ? 12'h529 : 12'h827)) begin errors++; $display("FAIL floor_gain got %h exp %h", bus.o_gain, WRAP ? 12'h529 : 12'h827); end
    checks++; if (bus.o_disp_value !== (WRAP ? 11'd5 : 11'h7F8)) begin errors++; $display("FAIL floor_disp got %h exp %h", bus.o_disp_value, WRAP ? 11'd5 : 11'h7F8); end
  endtask

  task automatic test_phase_edge();
    pulse_key(1);
    pulse_key(0);
    pulse_key(0);
    evt_cnt = 0;
    pulse_key(3);
    checks++; if (evt_cnt !== (WRAP ? 1 : 0)) begin errors++; $display("FAIL edge_dec_evts got %0d exp %0d", evt_cnt, WRAP ? 1 : 0); end
    checks++; if (bus.o_phase_step[29:20] !== (WRAP ? 10'd1023 : 10'd1)) begin errors++; $display("FAIL edge_dec_phase got %0d exp %0d", bus.o_phase_step[29:20], WRAP ? 1023 : 1); end
    evt_cnt = 0;
    pulse_key(2);
    checks++; if (evt_cnt !== 1) begin errors++; $display("FAIL edge_inc_evts got %0d exp 1", evt_cnt); end
    checks++; if (bus.o_phase_step !== (WRAP ? 30'h00104401 : 30'h00208401)) begin errors++; $display("FAIL edge_inc_phase got %h exp %h", bus.o_phase_step, WRAP ? 30'h00104401 : 30'h00208401); end
  endtask

  task automatic test_reset_mid_hold();
    bus.i_btn[2] = 1'b0;
    tick(8);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_gain !== 12'h111) begin errors++; $display("FAIL midrst_gain got %h exp %h", bus.o_gain, 12'h111); end
    checks++; if (bus.o_phase_step !== 30'h00100401) begin errors++; $display("FAIL midrst_phase got %h exp %h", bus.o_phase_step, 30'h00100401); end
    checks++; if (bus.o_field !== 1'b0) begin errors++; $display("FAIL midrst_field got %b exp 0", bus.o_field); end
    checks++; if (bus.o_disp_value !== 11'd1) begin errors++; $display("FAIL midrst_disp got %h exp 001", bus.o_disp_value); end
    @(negedge clk);
    bus.i_btn = 4'hF;
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.i_btn    = 4'hF;
    bus.i_ch_sel = 2'd0;
    bus.i_lock   = 1'b0;
    evt_cnt      = 0;
    test_reset();
    test_gain_inc();
    test_phase_field();
    test_hold_repeat();
    test_both_keys();
    test_lock();
    test_out_of_range();
    test_gain_floor();
    test_phase_edge();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_wave_panel_multi.md
Name: ctrl_wave_panel_multi

Overview:
- Parametrised front-panel controller for the DSP waveform generator. Generalises the fixed wave/noise control pair to NUM_CH independent channels.
- Each channel holds a signed gain and an NCO phase step.
- Four active-low board keys are synchronised and edge-detected. Held inc/dec keys auto-repeat. The key for the selected field/channel adjusts it with a selectable step size and saturation.
- Drives the NCO/gain inputs of the generator datapath and a registered display value for the 7-segment decoder.

Parameters:
- NUM_CH, 2, number of independent channels (>=1).
- SIZE_GAIN, 4, signed gain width per channel.
- SIZE_PHASE, 10, unsigned phase-step width per channel.
- GAIN_MAX, 7, upper gain clamp.
- GAIN_MIN, -8, lower gain clamp.
- HOLD_CYC, 25000000, cycles a key is held before auto-repeat starts (>=2).
- REPEAT_CYC, 5000000, cycles between auto-repeat events (>=1).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_btn  in  4  raw keys, active-low: [0] step-size cycle, [1] field toggle, [2] increment, [3] decrement
- i_ch_sel  in  max(1,$clog2(NUM_CH))  channel being edited; values >= NUM_CH are ignored (no edits)
- i_lock  in  1  1 = all edits blocked
- o_gain  out  NUM_CH*SIZE_GAIN  packed signed gains, channel 0 in LSBs
- o_phase_step  out  NUM_CH*SIZE_PHASE  packed phase steps, channel 0 in LSBs
- o_field  out  1  0 = gain field selected, 1 = phase field selected
- o_step_idx  out  2  current step size: 0 -> 1, 1 -> 4, 2 -> 16
- o_disp_value  out  SIZE_PHASE+1  signed value of the selected field of the selected channel
- o_evt  out  1  one-cycle pulse when any setting register changes

Behaviour:
- Reset values: every gain = 1, every phase step = 1, o_field = 0, o_step_idx = 0, o_disp_value = 1, o_evt = 0. Reset takes effect asynchronously, including mid-repeat and mid-hold: all counters clear and the repeat FSMs go to R_IDLE.
- Input path: each key passes through a 2-flop synchroniser. A press event is the synchronised level going 1->0 and lasts one cycle.
- Setting latency: key first sampled low at edge N; the target register holds its new value after edge N+2, and o_evt pulses in that same cycle.
- o_disp_value is registered from the settings and lags them by one cycle. Gain is sign-extended; phase step is zero-extended.
- btn0 press: o_step_idx advances 0 -> 1 -> 2 -> 0. The step applies to both fields.
- btn1 press: o_field toggles.
- Step size, field and channel are all global and persist across channel changes.
- Repeat FSM: states R_IDLE, R_WAIT, R_REP, with a shared counter.
  - R_IDLE: on an inc or dec press, emit one adjust event, clear the counter, go to R_WAIT.
  - R_WAIT: when the counter reaches HOLD_CYC-1, emit an event, clear the counter, go to R_REP.
  - R_REP: emit an event every REPEAT_CYC cycles.
  - From any state: key released -> R_IDLE.
  - inc and dec both synchronised-low: no events, go to R_IDLE. An inc press and a dec press in the same cycle are also ignored.
- Adjust, gain field: gain +/- step, computed at SIZE_GAIN+5 width, clamped to [GAIN_MIN, GAIN_MAX].
- Adjust, phase field: phase step +/- step, clamped to [1, 2^SIZE_PHASE-1]. Zero is never produced.
- o_evt pulses only when the stored value actually changes. Saturated no-ops and blocked edits give no pulse.
- i_lock = 1: adjust, step and field events are discarded. Repeat FSMs keep running but have no effect. Outputs hold.
- i_ch_sel out of range: adjust events are discarded, o_disp_value holds its last value, step/field events still apply.
- i_ch_sel may change at any cycle. Edits target the channel sampled in the event cycle, and o_disp_value follows the new channel one cycle later.
- Simultaneous btn0/btn1 events with an adjust event: all apply. The adjust uses the pre-update step and field values.

Optional Feature:
- Macro PANEL_WRAP_EN.
- Defined: values wrap instead of clamping.
  - Gain: above GAIN_MAX -> GAIN_MIN + overflow - 1; below GAIN_MIN -> GAIN_MAX - underflow + 1.
  - Phase: modular within [1, 2^SIZE_PHASE-1]; e.g. 1023 + 1 -> 1 and 1 - 4 -> 1020 for SIZE_PHASE = 10.
  - o_evt pulses on every event.
- Undefined: saturation as specified in Behaviour.

Test Plan:
- Reset, then ch0, gain field: 3 inc presses at step 1 -> ch0 gain 4, three o_evt pulses, o_disp_value = 4; ch1 unchanged at 1.
- Phase field (btn1), step 16 (btn0 twice), ch1: dec once from 1 -> stays 1, no o_evt. Then 2 incs -> 33.
- HOLD_CYC = 4, REPEAT_CYC = 2, gain field, inc held 12 cycles -> events at press, +4 and then every 2 cycles; gain clamps at 7; o_evt stops at saturation.
- inc and dec held together for 10 cycles -> no change, no o_evt. Release dec -> next inc press increments normally.
- i_lock = 1 during 5 inc presses -> outputs unchanged. Assert i_rst_n low mid-hold -> all gains and phases read 1 immediately.
- With PANEL_WRAP_EN: gain 7, inc step 1 -> -8; phase 1023, inc step 1 -> 1; o_evt pulses on each.
